z80_bus_responder: RTL and testbench
====================================

Name: z80_bus_responder

Overview:
Memory/IO responder for the Z80 bus driven by the tv80s core. It decodes mreq_n/iorq_n/rd_n/wr_n/m1_n/rfsh_n and serves read data from an internal byte array. It commits writes to that array, inserts programmable wait states via wait_n, and answers interrupt-acknowledge cycles with a vector byte. A backdoor port lets benches preload and inspect contents; this makes it the synthesizable replacement for the behavioural bench memory.

Parameters:
ADDR_BITS, 16, byte-array address width; depth 2**ADDR_BITS
IO_PAGE, 8'h10, high byte prepended to a[7:0] to form the IO array index
MEM_WAITS, 0, wait states inserted on memory read/write (0..15)
IO_WAITS, 0, wait states inserted on IO read/write, in addition to the core's automatic TW (0..15)
ROM_TOP, 16'h0FFF, last address of the protected region (used only with the optional feature)

Ports:
clk  in  1  bus clock, rising-edge
reset  in  1  asynchronous, active-high
a  in  16  CPU address bus
d_in  in  8  CPU data out (write data)
d_out  out  8  data to CPU di
mreq_n  in  1  memory request
iorq_n  in  1  IO request
rd_n  in  1  read strobe
wr_n  in  1  write strobe
m1_n  in  1  opcode fetch / INTA qualifier
rfsh_n  in  1  refresh qualifier
wait_n  out  1  wait request to CPU
int_vec  in  8  byte returned on INTA
int_ack  out  1  one-clock pulse per INTA cycle
bd_we  in  1  backdoor write enable
bd_addr  in  ADDR_BITS  backdoor address
bd_wdata  in  8  backdoor write data
bd_rdata  out  8  backdoor read data, registered, one-clock latency
wr_blocked  out  1  one-clock pulse when a ROM write is suppressed

Behaviour:
- Reset (async): state IDLE, wait_n=1, d_out=8'hFF, int_ack=0, wr_blocked=0, bd_rdata=0, wait counter=0. Array contents are not cleared.
- Cycle classification is sampled on rising clk in IDLE, in priority order:
  - INTA: iorq_n=0, m1_n=0.
  - IORD: iorq_n=0, rd_n=0.
  - IOWR: iorq_n=0, wr_n=0.
  - MEMRD: mreq_n=0, rd_n=0, rfsh_n=1.
  - MEMWR: mreq_n=0, wr_n=0.
  - Anything else, including a refresh (mreq_n=0, rfsh_n=0), is ignored and the block stays in IDLE.
- Index: memory uses a[ADDR_BITS-1:0]. IO uses {IO_PAGE,a[7:0]}, truncated to ADDR_BITS.
- States: IDLE -> WAIT (when N>0) or DATA (when N=0) -> DATA -> IDLE. N is MEM_WAITS or IO_WAITS; INTA uses N=0.
- WAIT:
  - wait_n=0 is registered on the detect edge, so it is low before the CPU samples it on the T2 falling edge.
  - The counter loads N and decrements each clock. At count 1, the next state is DATA and wait_n returns to 1.
  - wait_n is low for exactly N clocks.
- DATA entry edge:
  - Reads: d_out <= array[index].
  - Writes: array[index] <= d_in. Exactly one commit per access.
  - INTA: d_out <= int_vec and int_ack=1 for that single clock.
- DATA exit: hold d_out until both mreq_n and iorq_n are high, then go to IDLE. d_out keeps its last value.
- Zero waits: data is valid one clock after the strobes are detected, which is ahead of the T3 sample.
- A strobe that deasserts while in WAIT aborts to IDLE with no write commit and wait_n=1.
- Backdoor: a bd_we write takes effect every clock regardless of state. If a CPU write and a backdoor write hit the same index on the same edge, the CPU write wins. bd_rdata <= array[bd_addr] every clock.
- Reset asserted mid-access: immediate return to IDLE with wait_n=1. An uncommitted write is discarded.

Optional Feature:
Z80_RESP_ROM_PROTECT_EN.
- Defined: a MEMWR with index <= ROM_TOP is not committed and pulses wr_blocked for one clock on the DATA entry edge. Wait timing is unchanged. IO writes and backdoor writes are never blocked.
- Undefined: all memory writes commit, wr_blocked is tied to 0, and ROM_TOP is unused.

Test Plan:
- MEM_WAITS=0, backdoor 0x0000=0x06 and 0x0001=0xBC; release the tv80s from reset so it executes LD B,0xBC -> B=0xBC, PC=0x0002, wait_n never low.
- MEM_WAITS=2, MEMRD of 0x1234 holding 0xA5 -> wait_n low for exactly 2 clocks, d_out=0xA5 on the DATA entry edge.
- MEMWR 0x5A to 0x8000 with strobes held 3 clocks -> bd_rdata at 0x8000 = 0x5A, exactly one commit; a simultaneous bd write of 0x11 to 0x8000 loses.
- IOWR 0x77 to port 0x34, then IORD of port 0x34 -> array[0x1034]=0x77, d_out=0x77.
- Refresh cycle (mreq_n=0, rfsh_n=0), then INTA with int_vec=0xFF -> no state change on the refresh; on the INTA, d_out=0xFF and int_ack high for exactly 1 clock.
- Protect feature defined: MEMWR 0x99 to 0x0010 -> array unchanged, wr_blocked pulses once. Feature undefined -> array[0x0010]=0x99, wr_blocked stays 0.

Source files
------------

// File: rtl/z80_bus_responder.sv
// z80_bus_responder: Z80 memory/IO bus responder with a byte array, programmable
// wait states, an interrupt-acknowledge vector and a backdoor port.
// Optional feature macro: Z80_RESP_ROM_PROTECT_EN. It suppresses memory writes to
// indices 0..ROM_TOP and pulses wr_blocked when it does.
module z80_bus_responder #(
  parameter int unsigned ADDR_BITS = 16,
  parameter logic [7:0]  IO_PAGE   = 8'h10,
  parameter int unsigned MEM_WAITS = 0,
  parameter int unsigned IO_WAITS  = 0,
  parameter logic [15:0] ROM_TOP   = 16'h0FFF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [15:0]          a,
  input  logic [7:0]           d_in,
  output logic [7:0]           d_out,
  input  logic                 mreq_n,
  input  logic                 iorq_n,
  input  logic                 rd_n,
  input  logic                 wr_n,
  input  logic                 m1_n,
  input  logic                 rfsh_n,
  output logic                 wait_n,
  input  logic [7:0]           int_vec,
  output logic                 int_ack,
  input  logic                 bd_we,
  input  logic [ADDR_BITS-1:0] bd_addr,
  input  logic [7:0]           bd_wdata,
  output logic [7:0]           bd_rdata,
  output logic                 wr_blocked
);

  localparam int unsigned DEPTH = 1 << ADDR_BITS;
  localparam int unsigned CW    = 4;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;

  localparam logic [2:0] K_NONE  = 3'd0;
  localparam logic [2:0] K_INTA  = 3'd1;
  localparam logic [2:0] K_IORD  = 3'd2;
  localparam logic [2:0] K_IOWR  = 3'd3;
  localparam logic [2:0] K_MEMRD = 3'd4;
  localparam logic [2:0] K_MEMWR = 3'd5;

  localparam logic [CW-1:0] MEM_N = CW'(MEM_WAITS);
  localparam logic [CW-1:0] IO_N  = CW'(IO_WAITS);

  logic [7:0] mem_q [DEPTH];

  logic [1:0]           state_q, state_d;
  logic [2:0]           kind_q, kind_d;
  logic [ADDR_BITS-1:0] idx_q, idx_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 wait_n_q, wait_n_d;
  logic [7:0]           d_out_q, d_out_d;
  logic                 int_ack_q, int_ack_d;
  logic                 wr_blocked_q, wr_blocked_d;
  logic [7:0]           bd_rdata_q;

  logic [2:0]           kind_c;
  logic [ADDR_BITS-1:0] idx_c;
  logic [CW-1:0]        n_c;
  logic                 strobe_c;
  logic                 entry_c;
  logic [2:0]           entry_kind_c;
  logic [ADDR_BITS-1:0] entry_idx_c;
  logic                 blocked_c;
  logic                 mem_we_c;

`ifndef Z80_RESP_ROM_PROTECT_EN
  logic unused_rom_top;
  assign unused_rom_top = ^ROM_TOP;
`endif

  // Classify the bus cycle in priority order and form its array index and wait count
  always_comb begin
    kind_c = K_NONE;
    if (!iorq_n && !m1_n)                kind_c = K_INTA;
    else if (!iorq_n && !rd_n)           kind_c = K_IORD;
    else if (!iorq_n && !wr_n)           kind_c = K_IOWR;
    else if (!mreq_n && !rd_n && rfsh_n) kind_c = K_MEMRD;
    else if (!mreq_n && !wr_n)           kind_c = K_MEMWR;

    if (kind_c == K_IORD || kind_c == K_IOWR) begin
      idx_c = ADDR_BITS'({IO_PAGE, a[7:0]});
      n_c   = IO_N;
    end else begin
      idx_c = ADDR_BITS'(a);
      n_c   = (kind_c == K_INTA) ? CW'(0) : MEM_N;
    end
  end

  // Strobes that must stay asserted while the latched access is stretched
  always_comb begin
    case (kind_q)
      K_IORD:  strobe_c = !iorq_n && !rd_n;
      K_IOWR:  strobe_c = !iorq_n && !wr_n;
      K_MEMRD: strobe_c = !mreq_n && !rd_n;
      K_MEMWR: strobe_c = !mreq_n && !wr_n;
      default: strobe_c = 1'b0;
    endcase
  end

  // Next-state, wait counter and DATA-entry actions
  always_comb begin
    state_d      = state_q;
    kind_d       = kind_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    wait_n_d     = wait_n_q;
    d_out_d      = d_out_q;
    int_ack_d    = 1'b0;
    wr_blocked_d = 1'b0;
    entry_c      = 1'b0;
    entry_kind_c = kind_q;
    entry_idx_c  = idx_q;
    blocked_c    = 1'b0;
    mem_we_c     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (kind_c != K_NONE) begin
          kind_d = kind_c;
          idx_d  = idx_c;
          cnt_d  = n_c;
          if (n_c != CW'(0)) begin
            state_d  = S_WAIT;
            wait_n_d = 1'b0;
          end else begin
            state_d      = S_DATA;
            entry_c      = 1'b1;
            entry_kind_c = kind_c;
            entry_idx_c  = idx_c;
          end
        end
      end
      S_WAIT: begin
        if (!strobe_c) begin
          state_d  = S_IDLE;
          wait_n_d = 1'b1;
        end else if (cnt_q == CW'(1)) begin
          state_d  = S_DATA;
          wait_n_d = 1'b1;
          entry_c  = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_DATA: begin
        if (mreq_n && iorq_n) state_d = S_IDLE;
      end
      default: begin
        state_d  = S_IDLE;
        wait_n_d = 1'b1;
      end
    endcase

`ifdef Z80_RESP_ROM_PROTECT_EN
    blocked_c = (entry_kind_c == K_MEMWR) && (32'(entry_idx_c) <= 32'(ROM_TOP));
`endif

    if (entry_c) begin
      case (entry_kind_c)
        K_IORD, K_MEMRD: d_out_d = mem_q[entry_idx_c];
        K_IOWR, K_MEMWR: begin
          mem_we_c     = !blocked_c && !reset;
          wr_blocked_d = blocked_c;
        end
        K_INTA: begin
          d_out_d   = int_vec;
          int_ack_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Control and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      kind_q       <= K_NONE;
      idx_q        <= '0;
      cnt_q        <= '0;
      wait_n_q     <= 1'b1;
      d_out_q      <= 8'hFF;
      int_ack_q    <= 1'b0;
      wr_blocked_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      kind_q       <= kind_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      wait_n_q     <= wait_n_d;
      d_out_q      <= d_out_d;
      int_ack_q    <= int_ack_d;
      wr_blocked_q <= wr_blocked_d;
    end
  end

  // Byte array: backdoor writes first so a same-index CPU write wins
  always_ff @(posedge clk) begin
    if (bd_we)    mem_q[bd_addr]     <= bd_wdata;
    if (mem_we_c) mem_q[entry_idx_c] <= d_in;
  end

  // Registered backdoor read port
  always_ff @(posedge clk or posedge reset) begin
    if (reset) bd_rdata_q <= 8'h00;
    else       bd_rdata_q <= mem_q[bd_addr];
  end

  assign d_out      = d_out_q;
  assign wait_n     = wait_n_q;
  assign int_ack    = int_ack_q;
  assign wr_blocked = wr_blocked_q;
  assign bd_rdata   = bd_rdata_q;

endmodule

// File: tb/tb_z80_bus_responder.sv
// Directed bench for z80_bus_responder: a zero-wait instance and a
// MEM_WAITS=2 / IO_WAITS=1 instance share one bus and one backdoor.
module tb_z80_bus_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] a = 16'h0000;
  logic [7:0]  d_in = 8'h00;
  logic        mreq_n = 1'b1, iorq_n = 1'b1, rd_n = 1'b1, wr_n = 1'b1;
  logic        m1_n = 1'b1, rfsh_n = 1'b1;
  logic [7:0]  int_vec = 8'h00;
  logic        bd_we = 1'b0;
  logic [15:0] bd_addr = 16'h0000;
  logic [7:0]  bd_wdata = 8'h00;

  logic [7:0]  d_out_z, d_out_w, bd_rdata_z, bd_rdata_w;
  logic        wait_n_z, wait_n_w, int_ack_z, int_ack_w, wr_blocked_z, wr_blocked_w;

  int n_cmp = 0;
  int n_err = 0;
  int w_low = 0;
  logic z_wait_seen = 1'b0;

`ifdef Z80_RESP_ROM_PROTECT_EN
  localparam logic [7:0] EXP_BLK = 8'h01;
  localparam logic [7:0] EXP_ROM = 8'h00;
`else
  localparam logic [7:0] EXP_BLK = 8'h00;
  localparam logic [7:0] EXP_ROM = 8'h99;
`endif

  z80_bus_responder u_dut_z (
    .clk(clk), .reset(reset), .a(a), .d_in(d_in), .d_out(d_out_z),
    .mreq_n(mreq_n), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n),
    .m1_n(m1_n), .rfsh_n(rfsh_n), .wait_n(wait_n_z), .int_vec(int_vec),
    .int_ack(int_ack_z), .bd_we(bd_we), .bd_addr(bd_addr), .bd_wdata(bd_wdata),
    .bd_rdata(bd_rdata_z), .wr_blocked(wr_blocked_z)
  );

  z80_bus_responder #(.MEM_WAITS(2), .IO_WAITS(1)) u_dut_w (
    .clk(clk), .reset(reset), .a(a), .d_in(d_in), .d_out(d_out_w),
    .mreq_n(mreq_n), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n),
    .m1_n(m1_n), .rfsh_n(rfsh_n), .wait_n(wait_n_w), .int_vec(int_vec),
    .int_ack(int_ack_w), .bd_we(bd_we), .bd_addr(bd_addr), .bd_wdata(bd_wdata),
    .bd_rdata(bd_rdata_w), .wr_blocked(wr_blocked_w)
  );

  always #5 clk = ~clk;

  // Track wait_n activity on the falling edge, where the CPU samples it
  always @(negedge clk) begin
    if (!wait_n_z) z_wait_seen <= 1'b1;
    if (!wait_n_w) w_low <= w_low + 1;
  end

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    mreq_n = 1'b1; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; m1_n = 1'b1; rfsh_n = 1'b1;
  endtask

  task automatic bd_write(input logic [15:0] addr, input logic [7:0] data);
    bd_we = 1'b1; bd_addr = addr; bd_wdata = data;
    tick();
    bd_we = 1'b0;
  endtask

  task automatic bd_check(input string tag, input logic [15:0] addr,
                          input logic [7:0] exp_z, input logic [7:0] exp_w);
    bd_addr = addr;
    tick();
    check_eq({tag, "_z"}, 16'(bd_rdata_z), 16'(exp_z));
    check_eq({tag, "_w"}, 16'(bd_rdata_w), 16'(exp_w));
  endtask

  initial begin
    #1 reset = 1'b1;
    tick(); tick();
    check_eq("rst_wait_n", 16'(wait_n_w), 16'h1);
    check_eq("rst_d_out", 16'(d_out_w), 16'hFF);
    check_eq("rst_int_ack", 16'(int_ack_z), 16'h0);
    check_eq("rst_wr_blocked", 16'(wr_blocked_w), 16'h0);
    check_eq("rst_bd_rdata", 16'(bd_rdata_z), 16'h00);
    reset = 1'b0;
    tick();

    // Opcode fetch of LD B,n then operand read, zero-wait instance
    bd_write(16'h0000, 8'h06);
    bd_write(16'h0001, 8'hBC);
    a = 16'h0000; m1_n = 1'b0; mreq_n = 1'b0; rd_n = 1'b0;
    tick();
    check_eq("fetch_op", 16'(d_out_z), 16'h06);
    bus_idle(); tick();
    a = 16'h0001; mreq_n = 1'b0; rd_n = 1'b0;
    tick();
    check_eq("fetch_operand", 16'(d_out_z), 16'hBC);
    bus_idle(); tick();

    // Memory read with two wait states
    bd_write(16'h1234, 8'hA5);
    w_low = 0;
    a = 16'h1234; mreq_n = 1'b0; rd_n = 1'b0;
    tick();
    check_eq("memrd_z0", 16'(d_out_z), 16'hA5);
    check_eq("memrd_w_low", 16'(wait_n_w), 16'h0);
    tick(); tick();
    check_eq("memrd_w_data", 16'(d_out_w), 16'hA5);
    check_eq("memrd_w_high", 16'(wait_n_w), 16'h1);
    tick();
    bus_idle(); tick();
    check_eq("memrd_wait_clocks", 16'(w_low), 16'd2);

    // Memory write held several clocks, backdoor collision, single commit
    a = 16'h8000; d_in = 8'h5A; mreq_n = 1'b0; wr_n = 1'b0;
    bd_we = 1'b1; bd_addr = 16'h8000; bd_wdata = 8'h11;
    tick();
    bd_we = 1'b0;
    tick(); tick(); tick();
    check_eq("memwr_cpu_wins_z", 16'(bd_rdata_z), 16'h5A);
    check_eq("memwr_commit_w", 16'(bd_rdata_w), 16'h5A);
    bd_we = 1'b1; bd_wdata = 8'h33;
    tick();
    bd_we = 1'b0;
    tick();
    check_eq("memwr_once_z", 16'(bd_rdata_z), 16'h33);
    check_eq("memwr_once_w", 16'(bd_rdata_w), 16'h33);
    bus_idle(); tick();

    // Strobe released during wait states aborts without committing
    bd_write(16'h9000, 8'h00);
    a = 16'h9000; d_in = 8'hEE; mreq_n = 1'b0; wr_n = 1'b0;
    tick();
    check_eq("abort_wait_low", 16'(wait_n_w), 16'h0);
    bus_idle(); tick();
    check_eq("abort_wait_high", 16'(wait_n_w), 16'h1);
    bd_check("abort_mem", 16'h9000, 8'hEE, 8'h00);

    // IO write then IO read of port 0x34
    a = 16'hAB34; d_in = 8'h77; iorq_n = 1'b0; wr_n = 1'b0;
    tick(); tick(); tick();
    bus_idle(); tick();
    bd_check("iowr_mem", 16'h1034, 8'h77, 8'h77);
    a = 16'h0034; iorq_n = 1'b0; rd_n = 1'b0;
    tick();
    check_eq("iord_z", 16'(d_out_z), 16'h77);
    check_eq("iord_w_low", 16'(wait_n_w), 16'h0);
    tick();
    check_eq("iord_w", 16'(d_out_w), 16'h77);
    check_eq("iord_w_high", 16'(wait_n_w), 16'h1);
    bus_idle(); tick();

    // Refresh is ignored, then interrupt acknowledge
    a = 16'h1234; mreq_n = 1'b0; rfsh_n = 1'b0; rd_n = 1'b0;
    tick(); tick();
    check_eq("rfsh_z", 16'(d_out_z), 16'h77);
    check_eq("rfsh_w", 16'(d_out_w), 16'h77);
    check_eq("rfsh_wait", 16'(wait_n_w), 16'h1);
    bus_idle(); tick();
    int_vec = 8'hFF; iorq_n = 1'b0; m1_n = 1'b0;
    tick();
    check_eq("inta_vec", 16'(d_out_z), 16'hFF);
    check_eq("inta_ack_z", 16'(int_ack_z), 16'h1);
    check_eq("inta_ack_w", 16'(int_ack_w), 16'h1);
    check_eq("inta_wait", 16'(wait_n_w), 16'h1);
    tick();
    check_eq("inta_ack_z_end", 16'(int_ack_z), 16'h0);
    check_eq("inta_ack_w_end", 16'(int_ack_w), 16'h0);
    bus_idle(); tick();

    // Write into the protected region
    bd_write(16'h0010, 8'h00);
    a = 16'h0010; d_in = 8'h99; mreq_n = 1'b0; wr_n = 1'b0;
    tick();
    check_eq("rom_blk_z", 16'(wr_blocked_z), 16'(EXP_BLK));
    tick();
    check_eq("rom_blk_z_end", 16'(wr_blocked_z), 16'h0);
    tick();
    check_eq("rom_blk_w", 16'(wr_blocked_w), 16'(EXP_BLK));
    tick();
    check_eq("rom_blk_w_end", 16'(wr_blocked_w), 16'h0);
    bus_idle(); tick();
    bd_check("rom_mem", 16'h0010, EXP_ROM, EXP_ROM);

    // Reset asserted during wait states discards the pending write
    bd_write(16'hA000, 8'h00);
    a = 16'hA000; d_in = 8'h44; mreq_n = 1'b0; wr_n = 1'b0;
    tick();
    check_eq("midrst_wait_low", 16'(wait_n_w), 16'h0);
    #1 reset = 1'b1;
    #1;
    check_eq("midrst_wait_high", 16'(wait_n_w), 16'h1);
    check_eq("midrst_d_out", 16'(d_out_z), 16'hFF);
    bus_idle();
    tick(); tick();
    reset = 1'b0;
    tick();
    bd_check("midrst_mem", 16'hA000, 8'h44, 8'h00);

    check_eq("zero_wait_never_low", 16'(z_wait_seen), 16'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
